mem_access_stage: RTL and testbench

Memory-stage load/store unit for the pipelined OTTER core. Sits between the EtoM pipeline register and the MtoW register. Turns the M-stage load/store request into a req/ack transaction on the data-memory bus, stalls the pipeline until the transaction completes, and produces the aligned, sign/zero-extended load result `ReadDataM` that MtoW captures.

---
 rtl/mem_access_stage_if.sv | 31 +++
 rtl/mem_access_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// ---------------------------------------------------------------------------
// mem_access_stage_if
// Data-memory bus between the memory-stage load/store unit and the data RAM.
//   MemReq   : request, held high until the transaction is acknowledged
//   MemWe    : 1 = write, 0 = read
//   MemAddr  : word-aligned byte address (bits [1:0] always zero)
//   MemBe    : per-byte-lane enables
//   MemWData : store data, already replicated onto the addressed lanes
//   MemAck   : completion; MemRData is valid in the same cycle
//   MemRData : raw 32-bit read word
// master = load/store unit, slave = memory.
// ---------------------------------------------------------------------------
interface mem_access_stage_if;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [3:0]  MemBe;
    logic [31:0] MemWData;
    logic        MemAck;
    logic [31:0] MemRData;

    modport master (
        output MemReq, MemWe, MemAddr, MemBe, MemWData,
        input  MemAck, MemRData
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemBe, MemWData,
        output MemAck, MemRData
    );
endinterface

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// Memory-stage load/store unit of the pipelined OTTER core. Converts the
// M-stage load/store into a req/ack transaction on the data bus, stalls the
// pipeline while the transaction is outstanding and delivers the aligned,
// sign/zero-extended load result for the MtoW register.
//
// Ports
//   CLK, RST     : clock (rising edge), asynchronous active-high reset
//   MemReadM     : load in M stage
//   MemWriteM    : store in M stage (wins if both are set)
//   Funct3M      : access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   ALUResultM   : effective byte address
//   WriteDataM   : right-aligned store data
//   ReadDataM    : registered, formatted load data (holds otherwise)
//   StallM       : combinational stall request to the hazard unit
//   MisalignM    : combinational misaligned-access flag
//   bus          : data-memory bus (master side)
//
// Access timeline (ack in first BUSY cycle): IDLE(stall) -> BUSY(req, ack)
// -> DONE(no stall) -> IDLE. Each extra cycle of ack latency adds a BUSY.
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int XLEN = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                MemReadM,
    input  logic                MemWriteM,
    input  logic [2:0]          Funct3M,
    input  logic [XLEN-1:0]     ALUResultM,
    input  logic [XLEN-1:0]     WriteDataM,
    output logic [XLEN-1:0]     ReadDataM,
    output logic                StallM,
    output logic                MisalignM,
    mem_access_stage_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Bus-side and formatting state
    logic            mem_req_q,   mem_req_d;
    logic            mem_we_q,    mem_we_d;
    logic [31:0]     mem_addr_q,  mem_addr_d;
    logic [3:0]      mem_be_q,    mem_be_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic [2:0]      funct3_q,    funct3_d;
    logic [1:0]      offset_q,    offset_d;
    logic [31:0]     read_data_q, read_data_d;

    // Request decode
    logic        access;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        start;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;

    // Load formatting
    logic [7:0]  rd_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        sign_bit;
    logic [31:0] load_fmt;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign access  = MemReadM | MemWriteM;
    assign is_byte = (Funct3M[1:0] == 2'b00);
    assign is_half = (Funct3M[1:0] == 2'b01);
    // Funct3 x11 is not a legal RV32 load/store; treat it as a word so it
    // still gets the strictest alignment check.
    assign is_word = Funct3M[1];

    assign misaligned = (is_half & ALUResultM[0]) |
                        (is_word & (ALUResultM[1:0] != 2'b00));

    // A new transaction is only launched from IDLE; in BUSY/DONE the same
    // instruction is still being presented and must not be re-issued.
    assign start = (state_q == ST_IDLE) & access & ~misaligned;

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = WriteDataM[31:0];
        if (is_byte) begin
            be_calc    = 4'b0001 << ALUResultM[1:0];
            wdata_calc = {4{WriteDataM[7:0]}};
        end else if (is_half) begin
            be_calc    = 4'b0011 << {ALUResultM[1], 1'b0};
            wdata_calc = {2{WriteDataM[15:0]}};
        end
    end

    // ------------------------------------------------------------------
    // Load formatting from the latched size/offset
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
        assign rd_byte[gi] = bus.MemRData[8*gi +: 8];
    end

    assign sel_byte = rd_byte[offset_q];
    assign sel_half = offset_q[1] ? bus.MemRData[31:16] : bus.MemRData[15:0];

    always_comb begin
        sign_bit = 1'b0;
        load_fmt = bus.MemRData;
        case (funct3_q[1:0])
            2'b00: begin
                sign_bit = ~funct3_q[2] & sel_byte[7];
                load_fmt = {{24{sign_bit}}, sel_byte};
            end
            2'b01: begin
                sign_bit = ~funct3_q[2] & sel_half[15];
                load_fmt = {{16{sign_bit}}, sel_half};
            end
            default: load_fmt = bus.MemRData;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_BUSY;
            ST_BUSY: if (bus.MemAck) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        StallM = 1'b0;
        case (state_q)
            ST_IDLE: StallM = start;
            ST_BUSY: StallM = 1'b1;
            default: StallM = 1'b0;
        endcase
    end

    assign MisalignM = access & misaligned;

    // ------------------------------------------------------------------
    // Bus / load-data next values
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        read_data_d = read_data_q;

        if (start) begin
            mem_req_d   = 1'b1;
            mem_we_d    = MemWriteM;
            mem_addr_d  = {ALUResultM[31:2], 2'b00};
            mem_be_d    = be_calc;
            mem_wdata_d = wdata_calc;
            funct3_d    = Funct3M;
            offset_d    = ALUResultM[1:0];
        end

        // Request drops on the edge entering DONE; load data is captured on
        // the same edge so it is valid for the whole DONE cycle.
        if ((state_q == ST_BUSY) && bus.MemAck) begin
            mem_req_d = 1'b0;
            if (!mem_we_q) begin
                read_data_d = load_fmt;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            funct3_q    <= '0;
            offset_q    <= '0;
            read_data_q <= '0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
            read_data_q <= read_data_d;
        end
    end

    assign bus.MemReq   = mem_req_q;
    assign bus.MemWe    = mem_we_q;
    assign bus.MemAddr  = mem_addr_q;
    assign bus.MemBe    = mem_be_q;
    assign bus.MemWData = mem_wdata_q;
    assign ReadDataM    = read_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
// Directed bench for the memory-stage load/store unit. The bench plays the
// data memory, drives MemAck after a chosen number of BUSY cycles and checks
// stall length, bus fields and load formatting against hand-computed values.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic        CLK;
    logic        RST;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;

    mem_access_stage_if bus_if ();

    mem_access_stage #(.XLEN(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .bus        (bus_if)
    );

    int          n_checks;
    int          n_fail;
    logic [31:0] model_rd;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete aligned access. exp_load is the formatted load result;
    // stores must leave ReadDataM at its previous value.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rdat,
                             input int lat, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd, input logic [31:0] exp_load);
        int          stalls;
        int          busy;
        int          guard;
        logic [31:0] exp_final;
        stalls    = 0;
        busy      = 0;
        guard     = 0;
        exp_final = wr ? model_rd : exp_load;

        @(negedge CLK);
        MemReadM        = rd;
        MemWriteM       = wr;
        Funct3M         = f3;
        ALUResultM      = addr;
        WriteDataM      = wd;
        bus_if.MemAck   = 1'b0;
        bus_if.MemRData = 32'h5555_5555;
        #1;
        check({tag, "_misalign"}, {31'b0, MisalignM}, 32'd0);

        while (StallM && guard < 40) begin
            stalls++;
            if (bus_if.MemReq) begin
                busy++;
                check({tag, "_addr"}, bus_if.MemAddr, {addr[31:2], 2'b00});
                check({tag, "_be"}, {28'b0, bus_if.MemBe}, {28'b0, exp_be});
                check({tag, "_we"}, {31'b0, bus_if.MemWe}, {31'b0, wr});
                if (wr) check({tag, "_wdata"}, bus_if.MemWData, exp_wd);
                check({tag, "_rd_held"}, ReadDataM, model_rd);
                if (busy == lat) begin
                    bus_if.MemAck   = 1'b1;
                    bus_if.MemRData = rdat;
                end else begin
                    bus_if.MemAck   = 1'b0;
                    bus_if.MemRData = 32'h5555_5555;
                end
            end
            @(negedge CLK);
            #1;
            guard++;
        end
        if (guard >= 40) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: stall still high after %0d cycles, required release", tag, guard);
        end

        // Now in DONE
        check({tag, "_stalls"}, stalls, lat + 1);
        check({tag, "_busy"}, busy, lat);
        check({tag, "_rdata"}, ReadDataM, exp_final);
        check({tag, "_req_done"}, {31'b0, bus_if.MemReq}, 32'd0);
        model_rd = exp_final;
        $display("txn %s: rd=%0b wr=%0b addr=0x%08h stalls=%0d ReadDataM=0x%08h", tag, rd, wr, addr, stalls, ReadDataM);

        MemReadM      = 1'b0;
        MemWriteM     = 1'b0;
        bus_if.MemAck = 1'b0;
        @(negedge CLK);
        #1;
        check({tag, "_idle_stall"}, {31'b0, StallM}, 32'd0);
        check({tag, "_idle_rd"}, ReadDataM, exp_final);
    endtask

    task automatic do_misalign(input string tag, input logic [2:0] f3, input logic [31:0] addr);
        @(negedge CLK);
        MemReadM   = 1'b1;
        MemWriteM  = 1'b0;
        Funct3M    = f3;
        ALUResultM = addr;
        #1;
        check({tag, "_flag"}, {31'b0, MisalignM}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_stall"}, {31'b0, StallM}, 32'd0);
            check({tag, "_req"}, {31'b0, bus_if.MemReq}, 32'd0);
            @(negedge CLK);
            #1;
        end
        check({tag, "_rd"}, ReadDataM, model_rd);
        $display("txn %s: addr=0x%08h misaligned, no bus access", tag, addr);
        MemReadM = 1'b0;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        model_rd        = 32'd0;
        RST             = 1'b1;
        MemReadM        = 1'b0;
        MemWriteM       = 1'b0;
        Funct3M         = 3'b000;
        ALUResultM      = 32'd0;
        WriteDataM      = 32'd0;
        bus_if.MemAck   = 1'b0;
        bus_if.MemRData = 32'd0;

        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_req",   {31'b0, bus_if.MemReq}, 32'd0);
        check("rst_we",    {31'b0, bus_if.MemWe},  32'd0);
        check("rst_be",    {28'b0, bus_if.MemBe},  32'd0);
        check("rst_addr",  bus_if.MemAddr,  32'd0);
        check("rst_wdata", bus_if.MemWData, 32'd0);
        check("rst_rd",    ReadDataM,       32'd0);
        check("rst_stall", {31'b0, StallM}, 32'd0);
        $display("txn reset: outputs cleared");

        //        tag     rd    wr    f3    addr           wd             rdata          lat be       exp_wd         exp_load
        do_access("lw",   1'b1, 1'b0, F_W,  32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1, 4'b1111, 32'h0,         32'hDEAD_BEEF);
        do_access("lb",   1'b1, 1'b0, F_B,  32'h0000_0103, 32'h0,         32'h8012_3456, 1, 4'b1000, 32'h0,         32'hFFFF_FF80);
        do_access("lbu",  1'b1, 1'b0, F_BU, 32'h0000_0103, 32'h0,         32'h8012_3456, 1, 4'b1000, 32'h0,         32'h0000_0080);
        do_access("lh",   1'b1, 1'b0, F_H,  32'h0000_0102, 32'h0,         32'h8012_3456, 1, 4'b1100, 32'h0,         32'hFFFF_8012);
        do_access("lhu",  1'b1, 1'b0, F_HU, 32'h0000_0102, 32'h0,         32'h8012_3456, 2, 4'b1100, 32'h0,         32'h0000_8012);
        do_access("lb0",  1'b1, 1'b0, F_B,  32'h0000_0100, 32'h0,         32'h8012_3456, 1, 4'b0001, 32'h0,         32'h0000_0056);
        do_access("sb",   1'b0, 1'b1, F_B,  32'h0000_0102, 32'h0000_00AB, 32'h7777_7777, 1, 4'b0100, 32'hABAB_ABAB, 32'h0);
        do_access("sh",   1'b0, 1'b1, F_H,  32'h0000_0002, 32'h0000_1234, 32'h7777_7777, 1, 4'b1100, 32'h1234_1234, 32'h0);
        do_access("swrd", 1'b1, 1'b1, F_W,  32'h0000_0010, 32'hCAFE_F00D, 32'h7777_7777, 3, 4'b1111, 32'hCAFE_F00D, 32'h0);

        do_misalign("mis_lw", F_W, 32'h0000_0102);
        do_misalign("mis_lh", F_H, 32'h0000_0101);

        do_access("lw_slow", 1'b1, 1'b0, F_W, 32'h0000_0300, 32'h0, 32'h0BAD_F00D, 5, 4'b1111, 32'h0, 32'h0BAD_F00D);

        // Reset in the middle of a transaction, with a stale ack around it
        @(negedge CLK);
        MemReadM        = 1'b1;
        MemWriteM       = 1'b0;
        Funct3M         = F_W;
        ALUResultM      = 32'h0000_0200;
        bus_if.MemAck   = 1'b0;
        bus_if.MemRData = 32'h5555_5555;
        @(negedge CLK);
        #1;
        check("rstm_req_busy", {31'b0, bus_if.MemReq}, 32'd1);
        RST             = 1'b1;
        bus_if.MemAck   = 1'b1;
        bus_if.MemRData = 32'h9999_9999;
        #1;
        check("rstm_req_async",  {31'b0, bus_if.MemReq}, 32'd0);
        check("rstm_rd_async",   ReadDataM, 32'd0);
        check("rstm_addr_async", bus_if.MemAddr, 32'd0);
        check("rstm_stall",      {31'b0, StallM}, 32'd1);
        model_rd = 32'd0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rstm_req_idle", {31'b0, bus_if.MemReq}, 32'd0);
        check("rstm_stall_idle", {31'b0, StallM}, 32'd1);
        @(negedge CLK);
        #1;
        // Stale ack was seen only in IDLE; access restarted into BUSY
        check("rstm_req_restart", {31'b0, bus_if.MemReq}, 32'd1);
        check("rstm_rd_stale",    ReadDataM, 32'd0);
        check("rstm_addr_restart", bus_if.MemAddr, 32'h0000_0200);
        bus_if.MemAck   = 1'b1;
        bus_if.MemRData = 32'h1122_3344;
        @(negedge CLK);
        #1;
        check("rstm_stall_done", {31'b0, StallM}, 32'd0);
        check("rstm_rd_done",    ReadDataM, 32'h1122_3344);
        $display("txn rst_mid: restarted access ReadDataM=0x%08h", ReadDataM);
        MemReadM      = 1'b0;
        bus_if.MemAck = 1'b0;
        @(negedge CLK);
        #1;
        check("rstm_idle_stall", {31'b0, StallM}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute backstop so the run can never hang
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time 200000 reached, required earlier finish");
        $fatal(1);
    end

endmodule
